bank_reader: RTL and testbench

- Read-side and sequencing counterpart to the NU6509 bank register write path.
- Drives register readback onto the CPU data bus when the core reads $0000 (execution bank) or $0001 (indirection bank).
- Tracks the LDA (zp),Y ($B1) and STA (zp),Y ($91) sequences and selects the indirection bank for their data cycles.
- Sits between the 6502 core bus and the external bank-address outputs.

---
 rtl/bank_pkg.sv | 19 +
 rtl/bank_reader_ind_sequencer.sv | 49 ++++
 rtl/bank_reader.sv | 47 ++++
 tb/tb_bank_reader.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/bank_pkg.sv
// Shared definitions for the bank register read/sequencing path: FSM encoding,
// the two indirect-indexed opcodes that switch banks, and the register addresses.
package bank_pkg;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      ZP   = 3'd1,
      PLO  = 3'd2,
      PHI  = 3'd3,
      IND  = 3'd4
   } state_t;

   localparam logic [7:0] OP_LDA_INDY = 8'hB1;
   localparam logic [7:0] OP_STA_INDY = 8'h91;

   localparam int unsigned ADDR_EXEC_BANK = 0;
   localparam int unsigned ADDR_IND_BANK  = 1;

endpackage

// File: rtl/bank_reader_ind_sequencer.sv
// Tracks (zp),Y opcode sequences; ind_active rises in cycle 5 after the opcode fetch.
// Stalled read cycles (rdy low) hold state; write cycles always advance.
module ind_sequencer
   import bank_pkg::*;
(
   input  logic       clock,
   input  logic       reset,
   input  logic       rdy,
   input  logic       sync,
   input  logic       rw,
   input  logic [7:0] data_in,
   output logic       ind_active
);

   state_t state;
   state_t state_nxt;
   logic   adv;
   logic   op_hit;

   always_ff @(negedge clock or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      adv        = rdy | ~rw;
      op_hit     = (data_in == OP_LDA_INDY) || (data_in == OP_STA_INDY);
      state_nxt  = state;
      // Combinational on sync so the bank drops during the next opcode fetch itself.
      ind_active = (state == IND) & ~sync;

      if (adv) begin
         if (sync) begin
            state_nxt = op_hit ? ZP : IDLE;
         end else begin
            case (state)
               ZP:      state_nxt = PLO;
               PLO:     state_nxt = PHI;
               PHI:     state_nxt = IND;
               default: state_nxt = state;
            endcase
         end
      end
   end

endmodule

// File: rtl/bank_reader.sv
// Bank register readback at $0000/$0001 and A19..A16 bank selection; readback is
// combinational, bank switch follows ind_sequencer; rdy low stalls read cycles only.
module bank_reader
   import bank_pkg::*;
#(
   parameter int                      BANK_WIDTH = 4,
   parameter int                      ADDR_WIDTH = 16,
   parameter logic [BANK_WIDTH-1:0]   RESET_BANK = 4'hF,
   parameter logic [7-BANK_WIDTH:0]   PAD        = 4'h0
)(
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  rdy,
   input  logic                  sync,
   input  logic                  rw,
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic [7:0]            data_in,
   input  logic [BANK_WIDTH-1:0] exec_bank,
   input  logic [BANK_WIDTH-1:0] ind_bank,
   output logic [7:0]            data_out,
   output logic                  data_oe,
   output logic                  ind_active,
   output logic [BANK_WIDTH-1:0] bank_out
);

   ind_sequencer u_seq (
      .clock      (clock),
      .reset      (reset),
      .rdy        (rdy),
      .sync       (sync),
      .rw         (rw),
      .data_in    (data_in),
      .ind_active (ind_active)
   );

   always_comb begin
      data_oe  = rw & ((addr == ADDR_WIDTH'(ADDR_EXEC_BANK)) |
                       (addr == ADDR_WIDTH'(ADDR_IND_BANK)));
      data_out = 8'h00;
      if (data_oe) begin
         data_out = addr[0] ? {PAD, ind_bank} : {PAD, exec_bank};
      end
   end

   assign bank_out = ind_active ? ind_bank : exec_bank;

endmodule

// File: tb/tb_bank_reader.sv
// Directed bench for bank_reader: readback, LDA/STA (zp),Y sequencing, RDY stalls,
// asynchronous reset and back-to-back sequences.
module tb_bank_reader;

   localparam logic [3:0] EXEC_V = 4'h3;
   localparam logic [3:0] IND_V  = 4'hA;
   localparam logic [7:0] NOP    = 8'hEA;
   localparam logic [7:0] LDA    = 8'hB1;
   localparam logic [7:0] STA    = 8'h91;

   logic        clock;
   logic        reset;
   logic        rdy;
   logic        sync;
   logic        rw;
   logic [15:0] addr;
   logic [7:0]  data_in;
   logic [3:0]  exec_bank;
   logic [3:0]  ind_bank;
   logic [7:0]  data_out;
   logic        data_oe;
   logic        ind_active;
   logic [3:0]  bank_out;

   int checks = 0;
   int passes = 0;

   bank_reader dut (
      .clock      (clock),
      .reset      (reset),
      .rdy        (rdy),
      .sync       (sync),
      .rw         (rw),
      .addr       (addr),
      .data_in    (data_in),
      .exec_bank  (exec_bank),
      .ind_bank   (ind_bank),
      .data_out   (data_out),
      .data_oe    (data_oe),
      .ind_active (ind_active),
      .bank_out   (bank_out)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   task automatic chk_bus(input string tag, input logic exp_ind);
      chk({tag, ".ind"}, {7'd0, ind_active}, {7'd0, exp_ind});
      chk({tag, ".bank"}, {4'd0, bank_out}, exp_ind ? {4'd0, IND_V} : {4'd0, EXEC_V});
   endtask

   // One CPU cycle: inputs set after the falling edge, outputs checked mid-cycle.
   task automatic cyc(input string tag, input logic s, input logic r, input logic ry,
                      input logic [7:0] d, input logic exp_ind);
      sync    = s;
      rw      = r;
      rdy     = ry;
      data_in = d;
      addr    = 16'h2000;
      @(posedge clock);
      #1;
      chk_bus(tag, exp_ind);
      @(negedge clock);
      #1;
   endtask

   initial begin
      reset     = 1'b1;
      rdy       = 1'b1;
      sync      = 1'b0;
      rw        = 1'b1;
      addr      = 16'h0000;
      data_in   = 8'h00;
      exec_bank = EXEC_V;
      ind_bank  = IND_V;

      // Reset state and readback.
      #1;
      chk_bus("reset", 1'b0);
      chk("rb0.oe", {7'd0, data_oe}, 8'h01);
      chk("rb0.dat", data_out, 8'h03);
      addr = 16'h0001;
      #1;
      chk("rb1.oe", {7'd0, data_oe}, 8'h01);
      chk("rb1.dat", data_out, 8'h0A);
      rw = 1'b0;
      #1;
      chk("wr1.oe", {7'd0, data_oe}, 8'h00);
      chk("wr1.dat", data_out, 8'h00);
      rw   = 1'b1;
      addr = 16'h0002;
      #1;
      chk("rb2.oe", {7'd0, data_oe}, 8'h00);
      chk("rb2.dat", data_out, 8'h00);
      addr = 16'h0100;
      #1;
      chk("rb100.oe", {7'd0, data_oe}, 8'h00);
      @(negedge clock);
      #1;
      reset = 1'b0;

      // LDA (zp),Y without page cross.
      cyc("lda.c1", 1, 1, 1, LDA,   0);
      cyc("lda.c2", 0, 1, 1, 8'h10, 0);
      cyc("lda.c3", 0, 1, 1, 8'h00, 0);
      cyc("lda.c4", 0, 1, 1, 8'h20, 0);
      cyc("lda.c5", 0, 1, 1, 8'h55, 1);
      cyc("lda.c6", 1, 1, 1, NOP,   0);
      cyc("lda.c7", 0, 1, 1, 8'h00, 0);

      // STA (zp),Y: dummy read then write.
      cyc("sta.c1", 1, 1, 1, STA,   0);
      cyc("sta.c2", 0, 1, 1, 8'h10, 0);
      cyc("sta.c3", 0, 1, 1, 8'h00, 0);
      cyc("sta.c4", 0, 1, 1, 8'h20, 0);
      cyc("sta.c5", 0, 1, 1, 8'h00, 1);
      cyc("sta.c6", 0, 0, 1, 8'h77, 1);
      cyc("sta.c7", 1, 1, 1, NOP,   0);

      // STA with rdy low during the write: the write still completes.
      cyc("staw.c1", 1, 1, 1, STA,   0);
      cyc("staw.c2", 0, 1, 1, 8'h10, 0);
      cyc("staw.c3", 0, 1, 1, 8'h00, 0);
      cyc("staw.c4", 0, 1, 1, 8'h20, 0);
      cyc("staw.c5", 0, 1, 1, 8'h00, 1);
      cyc("staw.c6", 0, 0, 0, 8'h77, 1);
      cyc("staw.c7", 1, 1, 1, NOP,   0);
      cyc("staw.c8", 0, 1, 1, 8'h00, 0);

      // LDA with a 3-cycle read stall in PLO delays the switch by 3 cycles.
      cyc("stl.c1",  1, 1, 1, LDA,   0);
      cyc("stl.c2",  0, 1, 1, 8'h10, 0);
      cyc("stl.s1",  0, 1, 0, 8'h00, 0);
      cyc("stl.s2",  0, 1, 0, 8'h00, 0);
      cyc("stl.s3",  0, 1, 0, 8'h00, 0);
      cyc("stl.c3",  0, 1, 1, 8'h00, 0);
      cyc("stl.c4",  0, 1, 1, 8'h20, 0);
      cyc("stl.c5",  0, 1, 1, 8'h55, 1);
      // Stalled SYNC cycle: no decode, IND is held.
      cyc("stl.sy",  1, 1, 0, NOP,   0);
      cyc("stl.hld", 0, 1, 1, 8'h55, 1);
      cyc("stl.c6",  1, 1, 1, NOP,   0);
      cyc("stl.c7",  0, 1, 1, 8'h00, 0);

      // Stalled opcode fetch of $B1 in IDLE is not decoded.
      cyc("idl.sy",  1, 1, 0, LDA,   0);
      cyc("idl.c2",  0, 1, 1, 8'h00, 0);
      cyc("idl.c3",  0, 1, 1, 8'h00, 0);
      cyc("idl.c4",  0, 1, 1, 8'h00, 0);
      cyc("idl.c5",  0, 1, 1, 8'h00, 0);

      // Reset asserted in PHI aborts the sequence.
      cyc("rph.c1", 1, 1, 1, LDA,   0);
      cyc("rph.c2", 0, 1, 1, 8'h10, 0);
      cyc("rph.c3", 0, 1, 1, 8'h00, 0);
      sync    = 1'b0;
      data_in = 8'h20;
      @(posedge clock);
      #1;
      chk_bus("rph.c4", 1'b0);
      reset = 1'b1;
      #1;
      chk_bus("rph.rst", 1'b0);
      @(negedge clock);
      #1;
      reset = 1'b0;
      cyc("rph.c5", 0, 1, 1, 8'h55, 0);

      // Reset asserted in IND clears ind_active immediately.
      cyc("rind.c1", 1, 1, 1, LDA,   0);
      cyc("rind.c2", 0, 1, 1, 8'h10, 0);
      cyc("rind.c3", 0, 1, 1, 8'h00, 0);
      cyc("rind.c4", 0, 1, 1, 8'h20, 0);
      sync    = 1'b0;
      data_in = 8'h55;
      @(posedge clock);
      #1;
      chk_bus("rind.c5", 1'b1);
      reset = 1'b1;
      #1;
      chk_bus("rind.rst", 1'b0);
      @(negedge clock);
      #1;
      reset = 1'b0;
      cyc("rind.nop", 1, 1, 1, NOP,   0);
      cyc("rind.i2",  0, 1, 1, 8'h00, 0);
      cyc("rind.i3",  0, 1, 1, 8'h00, 0);
      cyc("rind.i4",  0, 1, 1, 8'h00, 0);
      cyc("rind.i5",  0, 1, 1, 8'h00, 0);

      // Back-to-back LDA then STA.
      cyc("b2b.l1", 1, 1, 1, LDA,   0);
      cyc("b2b.l2", 0, 1, 1, 8'h10, 0);
      cyc("b2b.l3", 0, 1, 1, 8'h00, 0);
      cyc("b2b.l4", 0, 1, 1, 8'h20, 0);
      cyc("b2b.l5", 0, 1, 1, 8'h55, 1);
      cyc("b2b.s1", 1, 1, 1, STA,   0);
      cyc("b2b.s2", 0, 1, 1, 8'h10, 0);
      cyc("b2b.s3", 0, 1, 1, 8'h00, 0);
      cyc("b2b.s4", 0, 1, 1, 8'h20, 0);
      cyc("b2b.s5", 0, 1, 1, 8'h00, 1);
      cyc("b2b.s6", 0, 0, 1, 8'h66, 1);
      cyc("b2b.s7", 1, 1, 1, NOP,   0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
